lossy_link_pipe: RTL and testbench
==================================

// Module: lossy_link_pipe
// PURPOSE
//  Parametrised lossy point-to-point link model for the ARQ formal and simulation benches.
//  Successor to the fixed link models: configurable width, delay, loss mode and injected stalls.
//  Hard bounds on consecutive errors and stalls make liveness provable without fairness assumptions.
//  Sits between arq_sender and arq_receiver (payload path) or receiver and sender (ack path).
// PARAMETERS
//  DATA_W          32  payload width in bits
//  DELAY           2   pipeline stages from accept to presentation; must be >= 1
//  LOSS_MODE       0   0 = DROP: errored beats never appear at out; 1 = FLAG: delivered with out_error=1
//  MAX_CONSEC_ERR  3   max consecutive errored accepted beats; 0 = lossless link
//  MAX_STALL       2   max consecutive cycles in_ready is forced low by stall_req; 0 = never stall
//  CNT_W           16  width of the saturating statistics counters
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous active-high reset
//  in_valid       in   1       upstream beat valid
//  in_ready       out  1       link accepts beat this cycle
//  in_payload     in   DATA_W  upstream beat
//  err_req        in   1       free/bench input: request corruption of the beat accepted this cycle
//  stall_req      in   1       free/bench input: request in_ready low this cycle
//  in_error       out  1       effective error for a beat accepted this cycle (err_req after bounding)
//  out_valid      out  1       downstream beat valid
//  out_ready      in   1       downstream accepts beat
//  out_payload    out  DATA_W  downstream beat
//  out_error      out  1       beat is errored (FLAG mode only; always 0 in DROP mode)
//  cnt_accepted   out  CNT_W   saturating count of accepted beats
//  cnt_errored    out  CNT_W   saturating count of accepted beats with in_error=1
// BEHAVIOUR
//  Reset: all stages invalid, counters 0. While rst=1: in_ready=0, out_valid=0, out_error=0, in_error=0.
//  Pipe: DELAY stages of {valid, error, payload}. Last stage drives out_*.
//  advance = !last.valid || out_ready. On advance, all stages shift by one and stage 0 loads the accept.
//  Non-collapsing: bubbles are kept. Latency is exactly DELAY cycles with out_ready held at 1.
//  Handshake:
//   - stall_eff = stall_req && (stall_cnt < MAX_STALL).
//   - in_ready  = advance && !stall_eff. It may depend on out_ready; no other combinational path from inputs.
//   - accept = in_valid && in_ready.
//   - out_valid is not retracted until out_ready; out_payload and out_error are stable while stalled.
//  stall_cnt: increments (saturating) when stall_eff; clears in any cycle where stall_eff=0.
//   - Guarantee: in_ready cannot be held low by stalls for more than MAX_STALL consecutive cycles.
//  Error:
//   - in_error = err_req && (err_cnt < MAX_CONSEC_ERR). It is combinational and valid regardless of accept.
//   - err_cnt changes only on accept: in_error=1 increments it; in_error=0 clears it.
//   - Hence after MAX_CONSEC_ERR errored accepts, the next accept is error-free.
//  DROP mode: an errored beat enters the pipe with valid=0 and is a bubble that consumes the slot.
//  FLAG mode: an errored beat enters with valid=1, error=1 and its payload passed unchanged.
//  Counters: cnt_accepted +1 per accept; cnt_errored +1 per accept with in_error=1.
//   - Both saturate at 2^CNT_W-1.
//  Simultaneous out consume and in accept in one cycle is legal and required for full throughput
//  (1 beat/cycle).
//  Async reset mid-transfer: in-flight beats are discarded; no beat is delivered after reset deasserts
//  unless it was accepted after reset.
//  Elaboration error if DELAY<1 or LOSS_MODE>1.
// TESTING
//  T1 DELAY=2, MODE=0, no err/stall, out_ready=1, stream 0x1..0x8 back-to-back:
//     out_valid from cycle 2, payloads 0x1..0x8 in order, 1 beat/cycle.
//  T2 MODE=0, MAX_CONSEC_ERR=3, err_req=1 constant, 8 accepts:
//     beats 1-3 and 5-7 dropped, beats 4 and 8 delivered; cnt_errored=6, cnt_accepted=8.
//  T3 MODE=1, err_req on beat 2 of 0xA,0xB,0xC:
//     all three delivered in order; out_error=1 only with 0xB.
//  T4 MAX_STALL=2, stall_req=1 for 6 cycles, in_valid=1:
//     in_ready pattern 0,0,1,0,0,1; accepts on cycles 3 and 6.
//  T5 out_ready=0 for 5 cycles with pipe full:
//     in_ready=0; out_payload stable; on release, no loss or duplication.
//  T6 assert rst with 2 beats in flight:
//     out_valid=0 immediately; nothing delivered post-reset until a new accept plus DELAY cycles.

Source files
------------

// File: rtl/lossy_link_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lossy_link_pipe                                            |
// | Description : Parametrised lossy point-to-point link. A fixed-latency,   |
// |               non-collapsing pipe with bounded error injection (drop or  |
// |               flag) and bounded ready stalls, plus saturating stats.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lossy_link_pipe #(
  parameter int DATA_W         = 32,
  parameter int DELAY          = 2,
  parameter int LOSS_MODE      = 0,
  parameter int MAX_CONSEC_ERR = 3,
  parameter int MAX_STALL      = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_payload,
  input  logic              err_req,
  input  logic              stall_req,
  output logic              in_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_payload,
  output logic              out_error,
  output logic [CNT_W-1:0]  cnt_accepted,
  output logic [CNT_W-1:0]  cnt_errored
);

  // Counter widths sized to hold the bound itself; a zero bound still needs one bit.
  localparam int c_stall_w = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
  localparam int c_err_w   = (MAX_CONSEC_ERR > 0) ? $clog2(MAX_CONSEC_ERR + 1) : 1;
  localparam logic [c_stall_w-1:0] c_max_stall = c_stall_w'(MAX_STALL);
  localparam logic [c_err_w-1:0]   c_max_err   = c_err_w'(MAX_CONSEC_ERR);
  localparam logic                 c_flag_mode = (LOSS_MODE == 1);

  // Reject configurations the pipe cannot represent.
  generate
    if (DELAY < 1) begin : g_bad_delay
      $error("lossy_link_pipe: DELAY must be >= 1");
    end
    if (LOSS_MODE < 0 || LOSS_MODE > 1) begin : g_bad_mode
      $error("lossy_link_pipe: LOSS_MODE must be 0 or 1");
    end
  endgenerate

  logic [DELAY-1:0]     r_valid;
  logic [DELAY-1:0]     r_err;
  logic [DATA_W-1:0]    r_data [DELAY];
  logic [c_stall_w-1:0] r_stall_cnt;
  logic [c_err_w-1:0]   r_err_cnt;
  logic [CNT_W-1:0]     r_cnt_acc;
  logic [CNT_W-1:0]     r_cnt_err;

  logic w_advance;
  logic w_stall_eff;
  logic w_accept;
  logic w_ld_valid;
  logic w_ld_err;

  // Handshake and error bounding; rst gating keeps in_ready/in_error low during reset.
  always_comb begin
    w_advance   = !r_valid[DELAY-1] || out_ready;
    w_stall_eff = stall_req && (r_stall_cnt < c_max_stall);
    in_ready    = !rst && w_advance && !w_stall_eff;
    in_error    = !rst && err_req && (r_err_cnt < c_max_err);
    w_accept    = in_valid && in_ready;
    // DROP mode turns an errored beat into a bubble that still occupies its slot.
    w_ld_valid  = w_accept && (c_flag_mode || !in_error);
    w_ld_err    = w_accept && in_error && c_flag_mode;
  end

  // Non-collapsing pipe: every stage shifts together whenever the tail can move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < DELAY; i++) begin
        r_data[i] <= '0;
      end
    end else if (w_advance) begin
      r_valid[0] <= w_ld_valid;
      r_err[0]   <= w_ld_err;
      r_data[0]  <= in_payload;
      for (int i = 1; i < DELAY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  // Stall run length: grows while a stall is honoured, clears on any unstalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_eff) begin
      r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
    end else begin
      r_stall_cnt <= '0;
    end
  end

  // Consecutive-error run length, updated only by accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_accept) begin
      if (in_error) begin
        r_err_cnt <= r_err_cnt + c_err_w'(1);
      end else begin
        r_err_cnt <= '0;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_acc <= '0;
      r_cnt_err <= '0;
    end else if (w_accept) begin
      if (r_cnt_acc != {CNT_W{1'b1}}) begin
        r_cnt_acc <= r_cnt_acc + CNT_W'(1);
      end
      if (in_error && (r_cnt_err != {CNT_W{1'b1}})) begin
        r_cnt_err <= r_cnt_err + CNT_W'(1);
      end
    end
  end

  assign out_valid    = r_valid[DELAY-1];
  assign out_error    = r_err[DELAY-1];
  assign out_payload  = r_data[DELAY-1];
  assign cnt_accepted = r_cnt_acc;
  assign cnt_errored  = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_lossy_link_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lossy_link_pipe                                         |
// | Description : Directed self-checking bench for lossy_link_pipe. Three    |
// |               instances share stimulus: DROP mode, FLAG mode, and DROP   |
// |               mode with 3-bit counters to reach saturation.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lossy_link_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_payload;
  logic        err_req;
  logic        stall_req;
  logic        out_ready;

  logic        d_in_ready, d_in_error, d_out_valid, d_out_error;
  logic [31:0] d_out_payload;
  logic [15:0] d_cnt_acc, d_cnt_err;

  logic        f_in_ready, f_in_error, f_out_valid, f_out_error;
  logic [31:0] f_out_payload;
  logic [15:0] f_cnt_acc, f_cnt_err;

  logic        s_in_ready, s_in_error, s_out_valid, s_out_error;
  logic [31:0] s_out_payload;
  logic [2:0]  s_cnt_acc, s_cnt_err;

  int n_checks;
  int n_fail;

  lossy_link_pipe #(
    .DATA_W(32), .DELAY(2), .LOSS_MODE(0), .MAX_CONSEC_ERR(3), .MAX_STALL(2), .CNT_W(16)
  ) u_drop (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_payload(in_payload), .err_req(err_req), .stall_req(stall_req),
    .in_error(d_in_error), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_payload(d_out_payload), .out_error(d_out_error),
    .cnt_accepted(d_cnt_acc), .cnt_errored(d_cnt_err)
  );

  lossy_link_pipe #(
    .DATA_W(32), .DELAY(2), .LOSS_MODE(1), .MAX_CONSEC_ERR(3), .MAX_STALL(2), .CNT_W(16)
  ) u_flag (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f_in_ready),
    .in_payload(in_payload), .err_req(err_req), .stall_req(stall_req),
    .in_error(f_in_error), .out_valid(f_out_valid), .out_ready(out_ready),
    .out_payload(f_out_payload), .out_error(f_out_error),
    .cnt_accepted(f_cnt_acc), .cnt_errored(f_cnt_err)
  );

  lossy_link_pipe #(
    .DATA_W(32), .DELAY(2), .LOSS_MODE(0), .MAX_CONSEC_ERR(3), .MAX_STALL(2), .CNT_W(3)
  ) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_payload(in_payload), .err_req(err_req), .stall_req(stall_req),
    .in_error(s_in_error), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_payload(s_out_payload), .out_error(s_out_error),
    .cnt_accepted(s_cnt_acc), .cnt_errored(s_cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Output-side check: valid always, payload/error only when a beat is expected.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic e,
                         input logic ev, input logic [31:0] ep, input logic ee);
    chk_eq({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
    if (ev) begin
      chk_eq({tag, "_payload"}, p, ep);
      chk_eq({tag, "_error"}, {31'd0, e}, {31'd0, ee});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] err_pat;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_payload = '0;
    err_req    = 1'b1;
    stall_req  = 1'b0;
    out_ready  = 1'b1;

    // Reset state, with err_req high to prove in_error is held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", {31'd0, d_in_ready}, 32'd0);
    chk_eq("rst_in_error", {31'd0, d_in_error}, 32'd0);
    chk_eq("rst_out_valid", {31'd0, d_out_valid}, 32'd0);
    chk_eq("rst_out_error", {31'd0, f_out_error}, 32'd0);
    chk_eq("rst_cnt_acc", {16'd0, d_cnt_acc}, 32'd0);
    chk_eq("rst_cnt_err", {16'd0, d_cnt_err}, 32'd0);
    next_cycle();
    rst     = 1'b0;
    err_req = 1'b0;

    // T1: back-to-back stream 1..8, first output two cycles after first accept.
    for (int c = 0; c <= 10; c++) begin
      in_valid   = (c < 8);
      in_payload = 32'(c + 1);
      @(negedge clk);
      chk_eq("t1_in_ready", {31'd0, d_in_ready}, 32'd1);
      chk_out("t1_drop", d_out_valid, d_out_payload, d_out_error,
              (c >= 2 && c <= 9), 32'(c - 1), 1'b0);
      next_cycle();
    end
    chk_eq("t1_cnt_acc", {16'd0, d_cnt_acc}, 32'd8);
    chk_eq("t1_sat_cnt_acc", {29'd0, s_cnt_acc}, 32'd7);

    // T2: err_req held; error run bounded at 3 so beats 4 and 8 are clean.
    err_pat = 8'b1000_1000;
    err_req = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      in_valid   = (c < 8);
      in_payload = 32'h11 + 32'(c);
      @(negedge clk);
      if (c < 8) begin
        chk_eq("t2_in_error", {31'd0, d_in_error}, {31'd0, ~err_pat[c]});
        chk_eq("t2_f_in_error", {31'd0, f_in_error}, {31'd0, ~err_pat[c]});
      end
      chk_out("t2_drop", d_out_valid, d_out_payload, d_out_error,
              (c == 5 || c == 9), 32'h11 + 32'(c - 2), 1'b0);
      chk_out("t2_flag", f_out_valid, f_out_payload, f_out_error,
              (c >= 2 && c <= 9), 32'h11 + 32'(c - 2),
              (c >= 2 && c <= 9) ? ~err_pat[(c - 2) % 8] : 1'b0);
      next_cycle();
    end
    err_req = 1'b0;
    chk_eq("t2_cnt_acc", {16'd0, d_cnt_acc}, 32'd16);
    chk_eq("t2_cnt_err", {16'd0, d_cnt_err}, 32'd6);
    chk_eq("t2_f_cnt_err", {16'd0, f_cnt_err}, 32'd6);
    chk_eq("t2_sat_cnt_acc", {29'd0, s_cnt_acc}, 32'd7);
    chk_eq("t2_sat_cnt_err", {29'd0, s_cnt_err}, 32'd6);

    // T3: error on the middle beat of 0xA,0xB,0xC.
    for (int c = 0; c <= 5; c++) begin
      in_valid   = (c < 3);
      in_payload = 32'hA + 32'(c);
      err_req    = (c == 1);
      @(negedge clk);
      if (c < 3) chk_eq("t3_in_error", {31'd0, d_in_error}, {31'd0, (c == 1)});
      chk_out("t3_flag", f_out_valid, f_out_payload, f_out_error,
              (c >= 2 && c <= 4), 32'hA + 32'(c - 2), (c == 3));
      chk_out("t3_drop", d_out_valid, d_out_payload, d_out_error,
              (c == 2 || c == 4), 32'hA + 32'(c - 2), 1'b0);
      next_cycle();
    end
    err_req = 1'b0;
    chk_eq("t3_cnt_err", {16'd0, d_cnt_err}, 32'd7);
    chk_eq("t3_sat_cnt_err", {29'd0, s_cnt_err}, 32'd7);

    // T4: stall_req held 6 cycles; ready pattern 0,0,1,0,0,1.
    for (int c = 0; c <= 8; c++) begin
      in_valid   = (c < 6);
      stall_req  = (c < 6);
      in_payload = 32'h40 + 32'(c);
      @(negedge clk);
      if (c < 6) chk_eq("t4_in_ready", {31'd0, d_in_ready}, {31'd0, (c == 2 || c == 5)});
      chk_out("t4_drop", d_out_valid, d_out_payload, d_out_error,
              (c == 4 || c == 7), 32'h40 + 32'(c - 2), 1'b0);
      next_cycle();
    end
    stall_req = 1'b0;
    chk_eq("t4_cnt_acc", {16'd0, d_cnt_acc}, 32'd21);

    // T5: downstream backpressure for 5 cycles with the pipe full.
    for (int c = 0; c <= 11; c++) begin
      logic [31:0] exp_p;
      logic        exp_v;
      in_valid   = (c <= 8);
      in_payload = (c == 0) ? 32'h51 : (c == 1) ? 32'h52 : (c <= 7) ? 32'h53 : 32'h54;
      out_ready  = !(c >= 2 && c <= 6);
      exp_v      = (c >= 2 && c <= 10);
      exp_p      = (c <= 7) ? 32'h51 : 32'h51 + 32'(c - 7);
      @(negedge clk);
      if (c <= 8) chk_eq("t5_in_ready", {31'd0, d_in_ready}, {31'd0, !(c >= 2 && c <= 6)});
      chk_out("t5_drop", d_out_valid, d_out_payload, d_out_error, exp_v, exp_p, 1'b0);
      next_cycle();
    end
    out_ready = 1'b1;
    chk_eq("t5_cnt_acc", {16'd0, d_cnt_acc}, 32'd25);

    // T6: reset with two beats in flight.
    for (int c = 0; c < 2; c++) begin
      in_valid   = 1'b1;
      in_payload = 32'h61 + 32'(c);
      next_cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    chk_eq("t6_rst_out_valid", {31'd0, d_out_valid}, 32'd0);
    chk_eq("t6_rst_in_ready", {31'd0, d_in_ready}, 32'd0);
    chk_eq("t6_rst_cnt_acc", {16'd0, d_cnt_acc}, 32'd0);
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_eq("t6_idle_out_valid", {31'd0, d_out_valid}, 32'd0);
      next_cycle();
    end
    for (int c = 0; c <= 3; c++) begin
      in_valid   = (c == 0);
      in_payload = 32'h63;
      @(negedge clk);
      if (c == 0) chk_eq("t6_in_ready", {31'd0, d_in_ready}, 32'd1);
      chk_out("t6_drop", d_out_valid, d_out_payload, d_out_error, (c == 2), 32'h63, 1'b0);
      next_cycle();
    end
    chk_eq("t6_cnt_acc", {16'd0, d_cnt_acc}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
